// File: rtl/lzc_pkg.sv
// ----------------------------------------------------------------------------
// lzc_pkg -- shared definitions for the leading-zero-count scheduler.
//
// Contents:
//   DEF_WIDTH / DEF_WORD / DEF_NREQ : default word width, words per operand,
//                                     and number of requesters.
//   state_t                         : scheduler FSM states (IDLE, BUSY, DONE).
//   cnt_w()                         : width of a count able to hold 0..width*word.
//   id_w()                          : width of a requester index (at least 1).
// ----------------------------------------------------------------------------
package lzc_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_WORD  = 4;
    localparam int DEF_NREQ  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // One extra bit so the all-zero total (width*word) is representable.
    function automatic int cnt_w(input int width, input int word);
        return $clog2(width * word) + 1;
    endfunction

    function automatic int id_w(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

endpackage

// File: rtl/lzc_word.sv
// ----------------------------------------------------------------------------
// lzc_word -- combinational leading-zero counter for a single data word.
//
// Parameters:
//   WIDTH : bits in the word
//   ZW    : width of the count (holds 0..WIDTH)
// Ports:
//   data  in  [WIDTH-1:0] : word to examine, MSB is bit WIDTH-1
//   zeros out [ZW-1:0]    : number of leading zeros, WIDTH when data is 0
// ----------------------------------------------------------------------------
module lzc_word #(
    parameter int WIDTH = 8,
    parameter int ZW    = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] data,
    output logic [ZW-1:0]    zeros
);

    // Scan upward; the highest set bit is the last one to overwrite the result.
    always_comb begin
        zeros = ZW'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (data[i]) begin
                zeros = ZW'(WIDTH - 1 - i);
            end
        end
    end

endmodule

// File: rtl/lzc_sched.sv
// ----------------------------------------------------------------------------
// lzc_sched -- shares one leading-zero-count engine between NREQ requesters.
// A granted requester streams WORD words (MSW first); the engine accumulates
// leading zeros up to the first nonzero word and reports the total together
// with the owning requester index.
//
// Build option:
//   LZC_SCHED_FIXED_PRIO_EN defined   : fixed priority, lowest index wins.
//   LZC_SCHED_FIXED_PRIO_EN undefined : round-robin starting at rr_ptr.
//
// Ports:
//   clk        in   : clock, rising edge
//   rst        in   : asynchronous active-high reset
//   req_valid  in   [NREQ]       : per-requester word valid
//   req_mode   in   [NREQ]       : per-requester mode (0 normal, 1 turbo)
//   req_data   in   [NREQ*WIDTH] : requester i at [i*WIDTH +: WIDTH]
//   req_ready  out  [NREQ]       : word accepted on valid & ready
//   res_valid  out              : result valid (held until res_ready)
//   res_ready  in               : result consumer ready
//   res_zeros  out  [CW]         : leading-zero count of the operand
//   res_id     out  [IW]         : owning requester index
// ----------------------------------------------------------------------------
module lzc_sched
    import lzc_pkg::*;
#(
    parameter int   WIDTH = DEF_WIDTH,
    parameter int   WORD  = DEF_WORD,
    parameter int   NREQ  = DEF_NREQ,
    localparam int  CW    = cnt_w(WIDTH, WORD),
    localparam int  IW    = id_w(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ-1:0]       req_mode,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [CW-1:0]         res_zeros,
    output logic [IW-1:0]         res_id
);

    localparam int WCW = $clog2(WORD + 1);
    localparam int ZW  = $clog2(WIDTH + 1);

    state_t           state_q, state_d;
    logic [IW-1:0]    gnt_q, gnt_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WCW-1:0]   wcnt_q, wcnt_d;
    logic             found_q, found_d;
    logic             mode_q, mode_d;

    logic [IW-1:0]    pick;
    logic             any_valid;
    logic [WIDTH-1:0] cur_word;
    logic [ZW-1:0]    word_zeros;
    logic             word_nz;
    logic             mode_eff;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
`ifdef LZC_SCHED_FIXED_PRIO_EN
    always_comb begin
        pick      = '0;
        any_valid = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                pick      = IW'(i);
                any_valid = 1'b1;
            end
        end
    end
`else
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;

    always_comb begin
        int idx;
        idx       = 0;
        pick      = '0;
        any_valid = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(rr_ptr_q) + i) % NREQ;
            if (!any_valid && req_valid[idx]) begin
                pick      = IW'(idx);
                any_valid = 1'b1;
            end
        end
    end

    // The pointer only advances once a result has actually been consumed.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (state_q == DONE && res_ready) begin
            rr_ptr_d = (gnt_q == IW'(NREQ - 1)) ? '0 : gnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Count engine
    // ------------------------------------------------------------------
    assign cur_word = req_data[int'(gnt_q) * WIDTH +: WIDTH];
    assign word_nz  = |cur_word;

    lzc_word #(
        .WIDTH (WIDTH),
        .ZW    (ZW)
    ) u_word (
        .data  (cur_word),
        .zeros (word_zeros)
    );

    // On the first word the live mode applies; afterwards the latched one.
    assign mode_eff = (wcnt_q == '0) ? req_mode[gnt_q] : mode_q;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        count_d = count_q;
        wcnt_d  = wcnt_q;
        found_d = found_q;
        mode_d  = mode_q;
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    gnt_d   = pick;
                    count_d = '0;
                    wcnt_d  = '0;
                    found_d = 1'b0;
                    mode_d  = 1'b0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (req_valid[gnt_q]) begin
                    if (wcnt_q == '0) begin
                        mode_d = req_mode[gnt_q];
                    end
                    // Words after the first nonzero one contribute nothing.
                    if (!found_q) begin
                        count_d = count_q + CW'(word_zeros);
                    end
                    if (word_nz) begin
                        found_d = 1'b1;
                    end
                    wcnt_d = wcnt_q + 1'b1;
                    if (wcnt_q == WCW'(WORD - 1) || (mode_eff && word_nz)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            count_q <= '0;
            wcnt_q  <= '0;
            found_q <= 1'b0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            count_q <= count_d;
            wcnt_q  <= wcnt_d;
            found_q <= found_d;
            mode_q  <= mode_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        req_ready = '0;
        if (state_q == BUSY) begin
            req_ready[gnt_q] = 1'b1;
        end
    end

    assign res_valid = (state_q == DONE);
    assign res_zeros = count_q;
    assign res_id    = gnt_q;

endmodule

// File: tb/tb_lzc_sched.sv
// ----------------------------------------------------------------------------
// tb_lzc_sched -- directed, table-driven bench for lzc_sched (default params).
// ----------------------------------------------------------------------------
module tb_lzc_sched;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_mode;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        res_valid;
    logic        res_ready;
    logic [5:0]  res_zeros;
    logic [1:0]  res_id;

    int checks;
    int errors;
    bit fixed_prio;

    lzc_sched dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_mode  (req_mode),
        .req_data  (req_data),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_zeros (res_zeros),
        .res_id    (res_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int               r;
        bit               mode;
        logic [3:0][7:0]  w;        // w[0] is the first (most significant) word
        int               stall;    // drop valid for 3 cycles after this many words (0 = none)
        int               hold;     // cycles to hold res_ready low in DONE
        int               exp_zeros;
        int               exp_words;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, expv);
        end
    endtask

    function automatic vec_t mk(input int r, input bit m,
                                input logic [7:0] w0, input logic [7:0] w1,
                                input logic [7:0] w2, input logic [7:0] w3,
                                input int st, input int hd, input int ez, input int ew);
        vec_t v;
        v.r = r; v.mode = m;
        v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
        v.stall = st; v.hold = hd; v.exp_zeros = ez; v.exp_words = ew;
        return v;
    endfunction

    task automatic run_job(input int row, input vec_t v);
        int acc;
        int guard;
        int stall_left;
        bit stalled;
        bit last_acc;
        bit was_ready;
        bit done;
        acc = 0; guard = 0; stall_left = 0; stalled = 0; last_acc = 0; done = 0;
        @(negedge clk);
        req_valid = 4'b1 << v.r;
        req_mode = '0;
        req_mode[v.r] = v.mode;
        req_data[v.r*8 +: 8] = v.w[0];
        while (!done && guard < 80) begin
            guard++;
            if (res_valid) begin
                done = 1;
            end else begin
                chk("only_gnt_ready", int'(req_ready & ~(4'b1 << v.r)), 0);
                was_ready = req_ready[v.r] & req_valid[v.r];
                @(posedge clk);
                last_acc = was_ready;
                if (was_ready) acc++;
                @(negedge clk);
                // Flip the mode after the first word: it must be ignored.
                if (acc >= 1) req_mode[v.r] = ~v.mode;
                if (acc < 4) req_data[v.r*8 +: 8] = v.w[acc];
                if (v.stall != 0 && acc == v.stall && !stalled) begin
                    stalled = 1;
                    stall_left = 3;
                end
                if (stall_left > 0) begin
                    req_valid = ~(4'b1 << v.r);
                    stall_left--;
                end else begin
                    req_valid = 4'b1 << v.r;
                end
            end
        end
        if (!done) begin
            chk("job_timeout", 0, 1);
            req_valid = '0;
            return;
        end
        chk("job_zeros", int'(res_zeros), v.exp_zeros);
        chk("job_id", int'(res_id), v.r);
        chk("job_words", acc, v.exp_words);
        chk("job_latency", int'(last_acc), 1);
        chk("job_ready_dropped", int'(req_ready), 0);
        $display("job %0d: req=%0d mode=%0d words=%0d zeros=%0d id=%0d",
                 row, v.r, v.mode, acc, res_zeros, res_id);
        req_valid = '0;
        for (int h = 0; h < v.hold; h++) begin
            @(posedge clk);
            @(negedge clk);
            chk("hold_valid", int'(res_valid), 1);
            chk("hold_zeros", int'(res_zeros), v.exp_zeros);
            chk("hold_id", int'(res_id), v.r);
            chk("hold_no_ready", int'(req_ready), 0);
        end
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
        chk("handshake_idle", int'(res_valid), 0);
    endtask

    initial begin
        int acc;
        int g;
        bit was;
        checks = 0;
        errors = 0;
`ifdef LZC_SCHED_FIXED_PRIO_EN
        fixed_prio = 1'b1;
`else
        fixed_prio = 1'b0;
`endif
        rst = 1'b1;
        req_valid = '0;
        req_mode = '0;
        req_data = '0;
        res_ready = 1'b0;

        vecs[0] = mk(0, 1'b0, 8'h00, 8'h00, 8'h10, 8'hFF, 0, 5, 19, 4);
        vecs[1] = mk(2, 1'b1, 8'h00, 8'h01, 8'hAA, 8'hBB, 0, 0, 15, 2);
        vecs[2] = mk(1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 32, 4);
        vecs[3] = mk(3, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 32, 4);
        vecs[4] = mk(1, 1'b0, 8'h01, 8'h00, 8'h00, 8'h00, 1, 0, 7, 4);
        vecs[5] = mk(3, 1'b1, 8'h00, 8'h00, 8'h00, 8'h80, 0, 0, 24, 4);
        vecs[6] = mk(2, 1'b0, 8'h00, 8'h40, 8'h00, 8'h00, 0, 0, 9, 4);

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_res_valid", int'(res_valid), 0);
        chk("reset_req_ready", int'(req_ready), 0);
        chk("reset_res_zeros", int'(res_zeros), 0);
        chk("reset_res_id", int'(res_id), 0);
        rst = 1'b0;

        // All requesters valid continuously: grant order
        @(negedge clk);
        req_valid = 4'hF;
        req_mode = '0;
        req_data = {8'h10, 8'h20, 8'h40, 8'h80};
        for (int j = 0; j < 5; j++) begin
            int expv;
            g = 0;
            expv = fixed_prio ? 0 : (j % 4);
            while (!res_valid && g < 40) begin
                @(negedge clk);
                g++;
            end
            if (!res_valid) begin
                chk("rr_timeout", 0, 1);
            end else begin
                chk("rr_id", int'(res_id), expv);
                chk("rr_zeros", int'(res_zeros), expv);
                $display("rr job %0d: id=%0d zeros=%0d", j, res_id, res_zeros);
            end
            res_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            res_ready = 1'b0;
        end
        req_valid = '0;

        // Table of single-requester jobs
        for (int k = 0; k < 7; k++) begin
            run_job(k, vecs[k]);
        end

        // Reset in the middle of a job (after 2 words)
        @(negedge clk);
        req_valid = 4'b0010;
        req_mode = '0;
        req_data = '0;
        acc = 0;
        g = 0;
        while (acc < 2 && g < 40) begin
            @(negedge clk);
            was = req_ready[1];
            @(posedge clk);
            if (was) acc++;
            g++;
        end
        chk("rst_prep_words", acc, 2);
        #2 rst = 1'b1;
        #1;
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_req_ready", int'(req_ready), 0);
        chk("rst_res_zeros", int'(res_zeros), 0);
        chk("rst_res_id", int'(res_id), 0);
        $display("reset mid-job after %0d words", acc);
        @(negedge clk);
        rst = 1'b0;
        req_valid = 4'b1010;
        req_data = {8'h0F, 8'h00, 8'h0F, 8'h00};
        g = 0;
        while (!res_valid && g < 40) begin
            @(negedge clk);
            g++;
        end
        if (!res_valid) begin
            chk("post_rst_timeout", 0, 1);
        end else begin
            chk("post_rst_id", int'(res_id), 1);
            chk("post_rst_zeros", int'(res_zeros), 4);
            $display("post-reset job: id=%0d zeros=%0d", res_id, res_zeros);
        end
        req_valid = '0;
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
        chk("post_rst_idle", int'(res_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
